// File: rtl/apb_uart_ctrl_pkg.sv
// Shared definitions for the apb_uart APB front-end: register map, FSM states,
// access classes, and the access-to-strobe mapping.
package apb_uart_ctrl_pkg;

  localparam int unsigned ADDR_BAUD   = 0;
  localparam int unsigned ADDR_FRAME  = 1;
  localparam int unsigned ADDR_PARITY = 2;
  localparam int unsigned ADDR_SBITS  = 3;
  localparam int unsigned ADDR_TX     = 4;
  localparam int unsigned ADDR_RX     = 5;

  typedef enum logic [1:0] {IDLE, DECODE, BUSY, RESP} ctrl_state_e;

  typedef enum logic [2:0] {
    ACC_CFG_WR,
    ACC_CFG_RD,
    ACC_TX,
    ACC_RX,
    ACC_ILLEGAL
  } access_e;

  // Strobe vector bit order: {rx, tx, cfg_rd, cfg_wr}
  function automatic logic [3:0] strobe_for(access_e acc);
    case (acc)
      ACC_CFG_WR: return 4'b0001;
      ACC_CFG_RD: return 4'b0010;
      ACC_TX:     return 4'b0100;
      ACC_RX:     return 4'b1000;
      default:    return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/apb_uart_ctrl_decode.sv
// Combinational classifier: maps an APB address and direction onto the core
// operation it requests, or ACC_ILLEGAL for unmapped/wrong-direction accesses.
module apb_uart_ctrl_decode
  import apb_uart_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write,
  output access_e               access
);

  always_comb begin
    access = ACC_ILLEGAL;
    if (addr <= ADDR_WIDTH'(ADDR_SBITS)) begin
      access = write ? ACC_CFG_WR : ACC_CFG_RD;
    end else if (addr == ADDR_WIDTH'(ADDR_TX) && write) begin
      access = ACC_TX;
    end else if (addr == ADDR_WIDTH'(ADDR_RX) && !write) begin
      access = ACC_RX;
    end
  end

endmodule

// File: rtl/apb_uart_ctrl.sv
// APB3 slave front-end for the apb_uart core: one access at a time, strobe held until the core
// answers. Optional BUSY watchdog enabled by defining APB_UART_CTRL_TIMEOUT_EN.
module apb_uart_ctrl
  import apb_uart_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] core_write_data,
  output logic [ADDR_WIDTH-1:0] core_addr,
  output logic                  core_tx_detect,
  output logic                  core_rx_detect,
  output logic                  core_cfg_wr_detect,
  output logic                  core_cfg_rd_detect,
  input  logic [DATA_WIDTH-1:0] core_read_data,
  input  logic                  core_ready,
  input  logic                  core_error
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit BUSY counter");
  end

  ctrl_state_e state, state_next;
  access_e access_in, access_q;
  logic write_q, err_q;
  logic [3:0] strobe_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic setup, core_done, timeout_hit;

  assign setup     = PSEL && !PENABLE;
  assign core_done = core_ready || core_error;

  apb_uart_ctrl_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_decode (
    .addr  (PADDR),
    .write (PWRITE),
    .access(access_in)
  );

`ifdef APB_UART_CTRL_TIMEOUT_EN
  logic [15:0] busy_cnt;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      busy_cnt <= '0;
    end else if (state == DECODE) begin
      busy_cnt <= '0;
    end else if (state == BUSY) begin
      busy_cnt <= busy_cnt + 16'd1;
    end
  end

  // A core answer arriving in the final allowed cycle still wins over the abort
  assign timeout_hit = (state == BUSY) && !core_done && (busy_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (setup) state_next = DECODE;
      DECODE:  state_next = (access_q == ACC_ILLEGAL) ? RESP : BUSY;
      BUSY:    if (core_done || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      access_q <= ACC_ILLEGAL;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      strobe_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            access_q <= access_in;
            write_q  <= PWRITE;
            addr_q   <= PADDR;
            wdata_q  <= PWDATA;
          end
        end
        DECODE: begin
          err_q    <= (access_q == ACC_ILLEGAL);
          strobe_q <= strobe_for(access_q);
        end
        BUSY: begin
          if (core_done) begin
            strobe_q <= '0;
            err_q    <= core_error;
            if (!write_q) rdata_q <= core_read_data;
          end else if (timeout_hit) begin
            strobe_q <= '0;
            err_q    <= 1'b1;
            rdata_q  <= '0;
          end
        end
        RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign PREADY             = (state == RESP);
  assign PSLVERR            = (state == RESP) && err_q;
  assign PRDATA             = rdata_q;
  assign core_addr          = addr_q;
  assign core_write_data    = wdata_q;
  assign core_cfg_wr_detect = strobe_q[0];
  assign core_cfg_rd_detect = strobe_q[1];
  assign core_tx_detect     = strobe_q[2];
  assign core_rx_detect     = strobe_q[3];

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Scoreboard bench for apb_uart_ctrl: an APB master issues random accesses, a core model answers
// strobes, and a monitor checks every PREADY against a queue of predicted responses.
module tb_apb_uart_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] core_write_data;
  logic [AW-1:0] core_addr;
  logic          core_tx_detect, core_rx_detect, core_cfg_wr_detect, core_cfg_rd_detect;
  logic [DW-1:0] core_read_data = '0;
  logic          core_ready = 1'b0, core_error = 1'b0;

  apb_uart_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .core_write_data(core_write_data), .core_addr(core_addr),
    .core_tx_detect(core_tx_detect), .core_rx_detect(core_rx_detect),
    .core_cfg_wr_detect(core_cfg_wr_detect), .core_cfg_rd_detect(core_cfg_rd_detect),
    .core_read_data(core_read_data), .core_ready(core_ready), .core_error(core_error)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // kind bits: {rx, tx, cfg_rd, cfg_wr}
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        pslverr;
    int          exp_cyc;
    logic [3:0]  kind;
    int          busy;
  } exp_t;

  typedef struct {
    int          delay;
    logic        err;
    logic        rdy;
    logic [31:0] rx_data;
  } core_t;

  exp_t  exp_q[$];
  core_t core_q[$];
  logic [31:0] ref_cfg[4];
  logic [31:0] core_cfg[4];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] cfg_reset_value(int idx);
    case (idx)
      0:       return 32'h0000_0364;
      1:       return 32'h0000_0008;
      2:       return 32'h0000_0000;
      default: return 32'h0000_0001;
    endcase
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Core model: answers each strobe after the delay chosen when the access was issued
  initial begin
    int cnt;
    logic active;
    core_t c;
    active = 1'b0;
    cnt = 0;
    c = '{delay: 1000000, err: 1'b0, rdy: 1'b0, rx_data: 32'h0};
    forever begin
      @(negedge PCLK);
      core_ready = 1'b0;
      core_error = 1'b0;
      core_read_data = $urandom();
      if (!PRESETn) begin
        active = 1'b0;
        for (int i = 0; i < 4; i++) core_cfg[i] = cfg_reset_value(i);
      end else if (!(core_tx_detect || core_rx_detect || core_cfg_wr_detect || core_cfg_rd_detect)) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          if (core_q.size() > 0) c = core_q.pop_front();
          else c = '{delay: 1000000, err: 1'b0, rdy: 1'b0, rx_data: 32'h0};
        end
        if (cnt == c.delay) begin
          core_ready = c.rdy;
          core_error = c.err;
          if (core_cfg_rd_detect) core_read_data = core_cfg[core_addr[1:0]];
          if (core_rx_detect) core_read_data = c.rx_data;
          if (core_cfg_wr_detect && !c.err) core_cfg[core_addr[1:0]] = core_write_data;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: tracks strobe activity and checks each completed access
  initial begin
    int strobe_cycles;
    logic [3:0] kind_seen;
    logic [3:0] strobes;
    logic bus_ok;
    exp_t e;
    strobe_cycles = 0;
    kind_seen = '0;
    bus_ok = 1'b1;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        strobe_cycles = 0;
        kind_seen = '0;
        bus_ok = 1'b1;
      end else begin
        strobes = {core_rx_detect, core_tx_detect, core_cfg_rd_detect, core_cfg_wr_detect};
        if ($countones(strobes) > 1) begin
          checks++;
          failures++;
          $display("[TB] FAIL onehot: got strobes 0x%0h expected at most one", strobes);
        end
        if (strobes != 0) begin
          strobe_cycles++;
          kind_seen |= strobes;
          if (exp_q.size() > 0) begin
            if (core_addr !== exp_q[0].addr) bus_ok = 1'b0;
            if (exp_q[0].write && core_write_data !== exp_q[0].wdata) bus_ok = 1'b0;
          end
        end
        if (PREADY) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_pready: got PREADY=1 expected no access pending");
          end else begin
            e = exp_q.pop_front();
            check_output("prdata", PRDATA, e.prdata);
            check_output("pslverr", 32'(PSLVERR), 32'(e.pslverr));
            check_output("latency", cyc, e.exp_cyc);
            check_output("strobe_kind", 32'(kind_seen), 32'(e.kind));
            check_output("strobe_cycles", strobe_cycles, e.busy);
            check_output("core_bus", 32'(bus_ok), 32'h1);
          end
          strobe_cycles = 0;
          kind_seen = '0;
          bus_ok = 1'b1;
        end
      end
    end
  end

  // Predicts the response from the register map and the chosen core behaviour, then drives APB
  task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                input int delay, input logic err, input logic rdy,
                                input logic [31:0] rx_data);
    exp_t e;
    bit seen;
    e.write = wr;
    e.addr = addr;
    e.wdata = data;
    e.kind = 4'b0000;
    if (addr < 4) e.kind = wr ? 4'b0001 : 4'b0010;
    else if (addr == 4 && wr) e.kind = 4'b0100;
    else if (addr == 5 && !wr) e.kind = 4'b1000;
    if (e.kind == 4'b0000) begin
      e.pslverr = 1'b1;
      e.prdata = 32'h0;
      e.busy = 0;
    end else begin
      e.busy = delay + 1;
      e.pslverr = err;
      e.prdata = wr ? 32'h0 : ((e.kind == 4'b0010) ? ref_cfg[addr[1:0]] : rx_data);
`ifdef APB_UART_CTRL_TIMEOUT_EN
      if (delay >= TO) begin
        e.busy = TO;
        e.pslverr = 1'b1;
        e.prdata = 32'h0;
      end
`endif
      if (e.kind == 4'b0001 && !err) ref_cfg[addr[1:0]] = data;
      core_q.push_back('{delay: delay, err: err, rdy: err ? rdy : 1'b1, rx_data: rx_data});
    end
    @(negedge PCLK);
    PSEL = 1'b1;
    PENABLE = 1'b0;
    PWRITE = wr;
    PADDR = addr;
    PWDATA = data;
    e.exp_cyc = cyc + 2 + e.busy;
    exp_q.push_back(e);
    @(negedge PCLK);
    PENABLE = 1'b1;
    PWDATA = $urandom();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge PCLK);
      if (PREADY) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL pready_wait: got no PREADY expected PREADY within 200 cycles");
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    PSEL = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic reset_during_busy();
    bit seen;
    core_q.push_back('{delay: 1000, err: 1'b0, rdy: 1'b1, rx_data: 32'h0});
    @(negedge PCLK);
    PSEL = 1'b1;
    PENABLE = 1'b0;
    PWRITE = 1'b1;
    PADDR = 32'h4;
    PWDATA = 32'h5A;
    @(negedge PCLK);
    PENABLE = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge PCLK);
      if (core_tx_detect) seen = 1'b1;
    end
    check_output("busy_tx_strobe", 32'(seen), 32'h1);
    PRESETn = 1'b0;
    @(negedge PCLK);
    check_output("rst_strobes",
                 32'({core_rx_detect, core_tx_detect, core_cfg_rd_detect, core_cfg_wr_detect}), 32'h0);
    check_output("rst_pready", 32'(PREADY), 32'h0);
    PSEL = 1'b0;
    PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    core_q.delete();
    for (int i = 0; i < 4; i++) ref_cfg[i] = cfg_reset_value(i);
    repeat (3) @(negedge PCLK);
  endtask

  initial begin
    logic wr;
    logic [31:0] addr;
    int delay;
    logic err;
    for (int i = 0; i < 4; i++) ref_cfg[i] = cfg_reset_value(i);
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    check_output("reset_pready", 32'(PREADY), 32'h0);
    check_output("reset_pslverr", 32'(PSLVERR), 32'h0);
    check_output("reset_prdata", PRDATA, 32'h0);
    check_output("reset_core_addr", core_addr, 32'h0);
    check_output("reset_core_wdata", core_write_data, 32'h0);
    check_output("reset_strobes",
                 32'({core_rx_detect, core_tx_detect, core_cfg_rd_detect, core_cfg_wr_detect}), 32'h0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    apply_stimulus(1'b0, 32'h1, 32'h0, 0, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b1, 32'h0, 32'h4B00, 0, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b1, 32'h5, 32'h77, 0, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b0, 32'h4, 32'h0, 0, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b1, 32'h9, 32'h11, 0, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b0, 32'h9, 32'h0, 0, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b1, 32'h4, 32'hA5, 4, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b0, 32'h5, 32'h0, 3, 1'b0, 1'b1, 32'hC3C3_0F0F);
    apply_stimulus(1'b0, 32'h2, 32'h0, 0, 1'b1, 1'b1, 32'h0);
    apply_stimulus(1'b0, 32'h5, 32'h0, 2, 1'b1, 1'b0, 32'h1234_5678);

    reset_during_busy();
    apply_stimulus(1'b0, 32'h1, 32'h0, 0, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b1, 32'h4, 32'h3C, 1, 1'b0, 1'b1, 32'h0);

`ifdef APB_UART_CTRL_TIMEOUT_EN
    apply_stimulus(1'b0, 32'h5, 32'h0, 100, 1'b0, 1'b1, 32'hDEAD_BEEF);
`endif

    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 7));
      delay = (addr == 4 || addr == 5) ? int'($urandom_range(0, 6)) : 0;
      err = ($urandom_range(0, 7) == 0);
      apply_stimulus(wr, addr, $urandom(), delay, err, 1'($urandom_range(0, 1)), $urandom());
    end

    repeat (5) @(negedge PCLK);
    check_output("drain", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
